mem_stage: RTL and testbench

- Memory-access stage of the RISC-V pipeline. Consumes the 76-bit EX/MEM bundle and performs the load or store against the data cache.
- Uses a request/busy handshake with the cache and stalls the pipeline while an access is outstanding.
- Formats load data and store byte lanes from fun_3.
- Registers the MEM/WB bundle consumed by the writeback stage.

---
 rtl/mem_stage.sv | 181 ++++++++++++++++++
 tb/tb_mem_stage.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access stage: issues loads/stores to the data cache, stalls while busy, registers MEM/WB.
// Optional misaligned-access trap is enabled with `define MEM_MISALIGN_TRAP_EN.
module mem_stage #(
   parameter int ADDR_W = 32,
   parameter int XLEN   = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [75:0]       ex_in,
   output logic              dmem_read,
   output logic              dmem_write,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [XLEN-1:0]   dmem_wdata,
   output logic [3:0]        dmem_byte_en,
   input  logic [XLEN-1:0]   dmem_rdata,
   input  logic              dmem_busy,
   output logic              stall,
`ifdef MEM_MISALIGN_TRAP_EN
   output logic              misalign_fault,
   output logic [31:0]       fault_addr,
`endif
   output logic [37:0]       mem_out
);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t state, next_state;

   logic [31:0] alu_result;
   logic [31:0] data_2;
   logic [2:0]  fun_3;
   logic        d_mem_w;
   logic        d_mem_r;
   logic [4:0]  write_address;
   logic        write_reg_en;
   logic        mux_d_mem;

   assign alu_result    = ex_in[31:0];
   assign data_2        = ex_in[63:32];
   assign fun_3         = ex_in[66:64];
   assign d_mem_w       = ex_in[67];
   assign d_mem_r       = ex_in[68];
   assign write_address = ex_in[73:69];
   assign write_reg_en  = ex_in[74];
   assign mux_d_mem     = ex_in[75];

   logic [1:0] a;
   logic       is_byte;
   logic       is_half;
   logic       pending;
   logic       misaligned;

   assign a       = alu_result[1:0];
   assign is_byte = (fun_3[1:0] == 2'b00);
   assign is_half = (fun_3[1:0] == 2'b01);
   assign pending = d_mem_r | d_mem_w;

`ifdef MEM_MISALIGN_TRAP_EN
   assign misaligned = (is_half && a[0]) || (!is_byte && !is_half && (a != 2'b00));
`else
   assign misaligned = 1'b0;
`endif

   // Access context captured on entry to ACCESS; the rest of ex_in is held by the stall.
   logic [1:0] addr_q;
   logic [2:0] fun3_q;

   logic [3:0]      st_byte_en;
   logic [XLEN-1:0] st_wdata;

   // NOTE: every signal written in always_comb gets a default first, otherwise a latch is inferred.
   always_comb begin
      st_byte_en = 4'b1111;
      st_wdata   = data_2;
      if (is_byte) begin
         st_byte_en = 4'b0001 << a;
         st_wdata   = {4{data_2[7:0]}};
      end else if (is_half) begin
         st_byte_en = a[1] ? 4'b1100 : 4'b0011;
         st_wdata   = {2{data_2[15:0]}};
      end
   end

   logic [7:0]      ld_byte;
   logic [15:0]     ld_half;
   logic [XLEN-1:0] ld_fmt;
   logic [31:0]     wb_data;

   always_comb begin
      case (addr_q)
         2'd0:    ld_byte = dmem_rdata[7:0];
         2'd1:    ld_byte = dmem_rdata[15:8];
         2'd2:    ld_byte = dmem_rdata[23:16];
         default: ld_byte = dmem_rdata[31:24];
      endcase
      ld_half = addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      case (fun3_q)
         3'b000:  ld_fmt = {{(XLEN-8){ld_byte[7]}}, ld_byte};
         3'b100:  ld_fmt = {{(XLEN-8){1'b0}}, ld_byte};
         3'b001:  ld_fmt = {{(XLEN-16){ld_half[15]}}, ld_half};
         3'b101:  ld_fmt = {{(XLEN-16){1'b0}}, ld_half};
         default: ld_fmt = dmem_rdata;
      endcase
      wb_data = mux_d_mem ? ld_fmt : alu_result;
   end

   always_comb begin
      next_state = state;
      stall      = 1'b0;
      case (state)
         IDLE: begin
            if (pending && !misaligned) begin
               stall      = 1'b1;
               next_state = ACCESS;
            end
         end
         ACCESS: begin
            if (dmem_busy) stall = 1'b1;
            else           next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
      // The pipeline must not see a stall while the stage is held in reset.
      if (!reset) stall = 1'b0;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         mem_out      <= '0;
         dmem_read    <= 1'b0;
         dmem_write   <= 1'b0;
         dmem_addr    <= '0;
         dmem_wdata   <= '0;
         dmem_byte_en <= '0;
         addr_q       <= '0;
         fun3_q       <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
         misalign_fault <= 1'b0;
         fault_addr     <= '0;
`endif
      end else begin
         state <= next_state;
`ifdef MEM_MISALIGN_TRAP_EN
         misalign_fault <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (!pending) begin
                  mem_out <= {write_reg_en, write_address, alu_result};
`ifdef MEM_MISALIGN_TRAP_EN
               end else if (misaligned) begin
                  mem_out        <= {1'b0, write_address, alu_result};
                  misalign_fault <= 1'b1;
                  fault_addr     <= alu_result;
`endif
               end else begin
                  // A simultaneous read and write resolves to the write.
                  dmem_read    <= d_mem_r & ~d_mem_w;
                  dmem_write   <= d_mem_w;
                  dmem_addr    <= {alu_result[ADDR_W-1:2], 2'b00};
                  dmem_wdata   <= d_mem_w ? st_wdata : '0;
                  dmem_byte_en <= d_mem_w ? st_byte_en : 4'b0000;
                  addr_q       <= a;
                  fun3_q       <= fun_3;
               end
            end
            ACCESS: begin
               if (!dmem_busy) begin
                  mem_out    <= {write_reg_en, write_address, wb_data};
                  dmem_read  <= 1'b0;
                  dmem_write <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: table of ALU/load/store vectors plus reset and busy corner sequences.
// Also exercises the misaligned trap when built with MEM_MISALIGN_TRAP_EN.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic [75:0] ex_in;
   logic        dmem_read;
   logic        dmem_write;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_byte_en;
   logic [31:0] dmem_rdata;
   logic        dmem_busy;
   logic        stall;
   logic [37:0] mem_out;
`ifdef MEM_MISALIGN_TRAP_EN
   logic        misalign_fault;
   logic [31:0] fault_addr;
`endif

   mem_stage #(.ADDR_W(32), .XLEN(32)) dut (
      .clk          (clk),
      .reset        (reset),
      .ex_in        (ex_in),
      .dmem_read    (dmem_read),
      .dmem_write   (dmem_write),
      .dmem_addr    (dmem_addr),
      .dmem_wdata   (dmem_wdata),
      .dmem_byte_en (dmem_byte_en),
      .dmem_rdata   (dmem_rdata),
      .dmem_busy    (dmem_busy),
      .stall        (stall),
`ifdef MEM_MISALIGN_TRAP_EN
      .misalign_fault (misalign_fault),
      .fault_addr     (fault_addr),
`endif
      .mem_out      (mem_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        mux;
      logic        wre;
      logic [4:0]  wa;
      logic        rd;
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] d2;
      logic [31:0] alu;
      logic [31:0] rdata;
      int          busy;
      logic [31:0] exp_wb;
      logic [3:0]  exp_be;
      logic [31:0] exp_wdata;
   } vec_t;

   vec_t        vecs[$];
   logic [37:0] exp_q[$];
   int          checks   = 0;
   int          failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      failures++;
      $display("FAIL %s: stall never released within cycle budget", name);
   endtask

   task automatic add(input string name, input logic mux, input logic wre, input logic [4:0] wa,
                      input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] d2,
                      input logic [31:0] alu, input logic [31:0] rdata, input int busy,
                      input logic [31:0] exp_wb, input logic [3:0] exp_be, input logic [31:0] exp_wdata);
      vec_t v;
      v.name = name; v.mux = mux; v.wre = wre; v.wa = wa; v.rd = rd; v.wr = wr; v.f3 = f3;
      v.d2 = d2; v.alu = alu; v.rdata = rdata; v.busy = busy;
      v.exp_wb = exp_wb; v.exp_be = exp_be; v.exp_wdata = exp_wdata;
      vecs.push_back(v);
   endtask

   function automatic logic [75:0] pack(input vec_t v);
      return {v.mux, v.wre, v.wa, v.rd, v.wr, v.f3, v.d2, v.alu};
   endfunction

   task automatic pop_check(input string name);
      logic [37:0] e;
      if (exp_q.size() == 0) begin
         timeout({name, "_empty_queue"});
      end else begin
         e = exp_q.pop_front();
         check({name, "_mem_out"}, {26'd0, mem_out}, {26'd0, e});
      end
   endtask

   // Entered just after a rising edge; leaves just after the edge that retires the instruction.
   task automatic run_vec(input vec_t v);
      int stall_cnt;
      int busy_left;
      int guard;
      ex_in      = pack(v);
      dmem_rdata = v.rdata;
      exp_q.push_back({v.wre, v.wa, v.exp_wb});
      if (!(v.rd || v.wr)) begin
         dmem_busy = (v.busy > 0);
         @(negedge clk);
         check({v.name, "_stall"}, {63'd0, stall}, 64'd0);
         @(posedge clk); #1;
         dmem_busy = 1'b0;
         pop_check(v.name);
      end else begin
         dmem_busy = 1'b0;
         @(negedge clk);
         check({v.name, "_idle_stall"}, {63'd0, stall}, 64'd1);
         @(posedge clk); #1;
         busy_left = v.busy;
         dmem_busy = (busy_left > 0);
         @(negedge clk);
         check({v.name, "_read"},  {63'd0, dmem_read},  {63'd0, v.rd & ~v.wr});
         check({v.name, "_write"}, {63'd0, dmem_write}, {63'd0, v.wr});
         check({v.name, "_addr"},  {32'd0, dmem_addr},  {32'd0, v.alu[31:2], 2'b00});
         check({v.name, "_be"},    {60'd0, dmem_byte_en}, {60'd0, v.exp_be});
         if (v.wr) check({v.name, "_wdata"}, {32'd0, dmem_wdata}, {32'd0, v.exp_wdata});
         stall_cnt = 1 + (stall ? 1 : 0);
         guard = 0;
         while (stall && guard < 50) begin
            @(posedge clk); #1;
            busy_left--;
            dmem_busy = (busy_left > 0);
            @(negedge clk);
            if (stall) stall_cnt++;
            guard++;
         end
         if (guard >= 50) timeout(v.name);
         check({v.name, "_stall_cycles"}, 64'(stall_cnt), 64'(1 + v.busy));
         @(posedge clk); #1;
         pop_check(v.name);
         check({v.name, "_req_drop"}, {62'd0, dmem_read, dmem_write}, 64'd0);
      end
   endtask

   initial begin
      vec_t v;
      //   name        mux wre wa  rd wr f3      d2            alu            rdata         busy wb            be       wdata
      add("alu",       0,  1,  5,  0, 0, 3'b000, 32'h0,        32'h0000_1234, 32'h0,        0,   32'h0000_1234, 4'b0000, 32'h0);
      add("lb_neg",    1,  1,  7,  1, 0, 3'b000, 32'h0,        32'h0000_0103, 32'h80FF_FF00, 0,  32'hFFFF_FF80, 4'b0000, 32'h0);
      add("lhu_busy",  1,  1,  9,  1, 0, 3'b101, 32'h0,        32'h0000_0102, 32'hBEEF_0000, 3,  32'h0000_BEEF, 4'b0000, 32'h0);
      add("alu_busy",  0,  1,  31, 0, 0, 3'b000, 32'h0,        32'hFFFF_FFFF, 32'h0,        1,   32'hFFFF_FFFF, 4'b0000, 32'h0);
      add("sb",        0,  0,  0,  0, 1, 3'b000, 32'h0000_00AB, 32'h0000_0021, 32'h0,       0,   32'h0000_0021, 4'b0010, 32'hABAB_ABAB);
      add("sh",        0,  0,  0,  0, 1, 3'b001, 32'h1234_CDEF, 32'h0000_0022, 32'h0,       1,   32'h0000_0022, 4'b1100, 32'hCDEF_CDEF);
      add("sw",        0,  0,  0,  0, 1, 3'b010, 32'hDEAD_BEEF, 32'h0000_0040, 32'h0,       2,   32'h0000_0040, 4'b1111, 32'hDEAD_BEEF);
      add("lw",        1,  1,  31, 1, 0, 3'b010, 32'h0,        32'h0000_0044, 32'h1357_9BDF, 2,  32'h1357_9BDF, 4'b0000, 32'h0);
      add("lh_hi",     1,  1,  12, 1, 0, 3'b001, 32'h0,        32'h0000_0012, 32'h8001_7FFF, 0,  32'hFFFF_8001, 4'b0000, 32'h0);
      add("lh_lo",     1,  1,  14, 1, 0, 3'b001, 32'h0,        32'h0000_0010, 32'h1234_8000, 0,  32'hFFFF_8000, 4'b0000, 32'h0);
      add("lbu",       1,  1,  13, 1, 0, 3'b100, 32'h0,        32'h0000_0011, 32'h0000_F200, 1,  32'h0000_00F2, 4'b0000, 32'h0);
      add("rw_both",   0,  0,  0,  1, 1, 3'b010, 32'h0000_0011, 32'h0000_0050, 32'h0,       0,   32'h0000_0050, 4'b1111, 32'h0000_0011);
      add("lb_pos",    1,  1,  2,  1, 0, 3'b000, 32'h0,        32'h0000_0100, 32'h0000_007F, 0,  32'h0000_007F, 4'b0000, 32'h0);
      add("lw_nomux",  0,  1,  4,  1, 0, 3'b010, 32'h0,        32'h0000_0200, 32'hCAFE_F00D, 0,  32'h0000_0200, 4'b0000, 32'h0);

      // Reset with a load pending on ex_in: outputs must be cleared and stall held low.
      reset      = 1'b0;
      dmem_busy  = 1'b0;
      dmem_rdata = 32'h0;
      ex_in      = {1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 3'b010, 32'h0, 32'h0000_0008};
      #12;
      check("rst_mem_out", {26'd0, mem_out}, 64'd0);
      check("rst_req",     {62'd0, dmem_read, dmem_write}, 64'd0);
      check("rst_addr",    {32'd0, dmem_addr}, 64'd0);
      check("rst_wdata",   {28'd0, dmem_byte_en, dmem_wdata}, 64'd0);
      check("rst_stall",   {63'd0, stall}, 64'd0);
      ex_in = '0;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;

      foreach (vecs[i]) run_vec(vecs[i]);

      // Reset asserted mid-access abandons the request without updating mem_out.
      v = vecs[7];
      v.name = "mid_rst";
      ex_in = pack(v);
      dmem_rdata = 32'h5555_AAAA;
      @(negedge clk);
      @(posedge clk); #1;
      dmem_busy = 1'b1;
      @(negedge clk);
      check("mid_rst_req_before", {63'd0, dmem_read}, 64'd1);
      #1 reset = 1'b0;
      #1;
      check("mid_rst_mem_out", {26'd0, mem_out}, 64'd0);
      check("mid_rst_req",     {62'd0, dmem_read, dmem_write}, 64'd0);
      check("mid_rst_addr",    {32'd0, dmem_addr}, 64'd0);
      check("mid_rst_stall",   {63'd0, stall}, 64'd0);
      dmem_busy = 1'b0;
      ex_in = {1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0000_0055};
      exp_q.push_back({1'b1, 5'd8, 32'h0000_0055});
      @(negedge clk);
      reset = 1'b1;
      #1 check("post_rst_stall", {63'd0, stall}, 64'd0);
      @(posedge clk); #1;
      pop_check("post_rst");
      check("post_rst_req", {62'd0, dmem_read, dmem_write}, 64'd0);

`ifdef MEM_MISALIGN_TRAP_EN
      // Misaligned word load: no request, one-cycle fault pulse, write_reg_en suppressed.
      ex_in = {1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 3'b010, 32'h0, 32'h0000_0006};
      exp_q.push_back({1'b0, 5'd3, 32'h0000_0006});
      @(negedge clk);
      check("mis_stall", {63'd0, stall}, 64'd0);
      @(posedge clk); #1;
      pop_check("mis");
      check("mis_fault",  {63'd0, misalign_fault}, 64'd1);
      check("mis_addr",   {32'd0, fault_addr}, 64'h6);
      check("mis_req",    {62'd0, dmem_read, dmem_write}, 64'd0);
      ex_in = '0;
      @(posedge clk); #1;
      check("mis_pulse_end", {63'd0, misalign_fault}, 64'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
